// File: rtl/mac_pkg.sv
// Shared constants for the MAC engine: FSM state encoding and default widths
// used by this block, the operand memory wrappers and the top-level controller.
package mac_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N      = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_ACC_W  = 20;

endpackage

// File: rtl/inner_mac_unit_if.sv
// Start/done handshake plus operand-memory read bus between the controller
// side (master) and the MAC engine (slave).
interface inner_mac_unit_if
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic                     inner_start;
    logic                     rd_en;
    logic [ADDR_W-1:0]        addr;
    logic signed [DATA_W-1:0] a_data;
    logic signed [DATA_W-1:0] b_data;
    logic                     busy;
    logic signed [ACC_W-1:0]  result;
    logic                     done;

    modport master (
        output inner_start, a_data, b_data,
        input  rd_en, addr, busy, result, done
    );

    modport slave (
        input  inner_start, a_data, b_data,
        output rd_en, addr, busy, result, done
    );
endinterface

// File: rtl/mac_datapath.sv
// Read-valid delay, signed multiply-accumulate and the result holding register.
// Memory data lags rd_en by one cycle, so accumulation is gated by v_q.
module mac_datapath
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     v,
    input  logic                     load_result,
    input  logic signed [DATA_W-1:0] a_data,
    input  logic signed [DATA_W-1:0] b_data,
    output logic signed [ACC_W-1:0]  result
);
    localparam int PROD_W = 2 * DATA_W;

    logic                    v_q, v_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] result_q, result_d;

    // Full-width signed product, sign-extended and added with modulo wrap.
    function automatic logic signed [ACC_W-1:0] mac_step(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] prod;
        prod = a * b;
        return acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

    always_comb begin
        v_d      = v;
        acc_d    = acc_q;
        result_d = result_q;
        if (clr) begin
            acc_d = '0;
        end else if (v_q) begin
            acc_d = mac_step(acc_q, a_data, b_data);
        end
        // The final product lands on the same edge that enters DONE.
        if (load_result) begin
            result_d = acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q      <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            v_q      <= v_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/inner_mac_unit.sv
// Run sequencer for the MAC engine: on inner_start walks N addresses, drains
// the read pipeline, then pulses done with the registered dot product.
module inner_mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input logic               clk,
    input logic               rst,
    inner_mac_unit_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr;
    logic              rd_en;
    logic              load_result;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.inner_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; inputs never reach them directly.
    assign rd_en       = (state_q == ST_RUN);
    assign load_result = (state_q == ST_DRAIN);

    assign bus.rd_en = rd_en;
    assign bus.addr  = rd_en ? cnt_q : '0;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);

    mac_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .v           (rd_en),
        .load_result (load_result),
        .a_data      (bus.a_data),
        .b_data      (bus.b_data),
        .result      (bus.result)
    );

endmodule

// File: tb/tb_inner_mac_unit.sv
// Scoreboard bench for inner_mac_unit: stimulus queues expected dot products,
// a negedge monitor checks done timing, result, busy span and address walk.
module tb_inner_mac_unit;
    import mac_pkg::*;

    localparam int DW       = DEF_DATA_W;
    localparam int NN       = DEF_N;
    localparam int AW       = DEF_ADDR_W;
    localparam int ACW      = DEF_ACC_W;
    localparam int LAT      = NN + 2;
    localparam int WATCHDOG = 5000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inner_mac_unit_if #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACW)) bus ();

    inner_mac_unit #(.DATA_W(DW), .N(NN), .ADDR_W(AW), .ACC_W(ACW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [DW-1:0] mem_a [NN];
    logic signed [DW-1:0] mem_b [NN];

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_data <= mem_a[bus.addr];
            bus.b_data <= mem_b[bus.addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                     cyc;
        logic signed [ACW-1:0]  res;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit finish_req = 1'b0;
    bit ctrl_ok    = 1'b0;

    // Reference: plain integer dot product, wrapped to the result width.
    function automatic logic signed [ACW-1:0] ref_dot();
        int s = 0;
        for (int i = 0; i < NN; i++) s += int'(mem_a[i]) * int'(mem_b[i]);
        return ACW'(s);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sole checker.
    int   exp_addr = 0;
    int   busy_len = 0;
    bit   prev_done = 1'b0;
    int   last_res = 0;
    exp_t e;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_rd_en",  int'(bus.rd_en),  0);
            chk("rst_addr",   int'(bus.addr),   0);
            chk("rst_busy",   int'(bus.busy),   0);
            chk("rst_done",   int'(bus.done),   0);
            chk("rst_result", int'(bus.result), 0);
            exp_addr  = 0;
            busy_len  = 0;
            prev_done = 1'b0;
            last_res  = 0;
        end else begin
            if (bus.rd_en) begin
                chk("addr_seq", int'(bus.addr), exp_addr);
                exp_addr++;
            end else begin
                chk("addr_idle", int'(bus.addr), 0);
                exp_addr = 0;
            end
            if (prev_done) chk("busy_after_done", int'(bus.busy), 0);
            if (bus.busy) busy_len++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("result", int'(bus.result), int'(e.res));
                    chk("busy_len", busy_len, LAT);
                    last_res = int'(e.res);
                end
            end else begin
                chk("result_hold", int'(bus.result), last_res);
            end
            if (!bus.busy) busy_len = 0;
            prev_done = bus.done;
        end
        if (finish_req || cyc > WATCHDOG) begin
            if (cyc > WATCHDOG) chk("watchdog", cyc, WATCHDOG);
            chk("outstanding", sb.size(), 0);
            chk("ctrl_return", int'(ctrl_ok), 1);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // Stimulus helpers; all called at a negedge.
    task automatic fill_const(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = $signed(8'($urandom));
            mem_b[i] = ($urandom_range(0, 7) == 0) ? -8'sd128 : $signed(8'($urandom));
        end
    endtask

    task automatic launch(input bit expect_done);
        exp_t x;
        bus.inner_start = 1'b1;
        if (expect_done) begin
            x.cyc = cyc + LAT;
            x.res = ref_dot();
            sb.push_back(x);
        end
        @(negedge clk);
        bus.inner_start = 1'b0;
    endtask

    int  ctl_state;
    bit  ctl_start;
    exp_t cx;

    initial begin
        bus.inner_start = 1'b0;
        fill_const(8'sd0, 8'sd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All ones: result 16.
        fill_const(8'sd1, 8'sd1);
        launch(1'b1);
        repeat (LAT) @(negedge clk);

        // -1 * 2 everywhere: -32.
        fill_const(-8'sd1, 8'sd2);
        launch(1'b1);
        repeat (LAT) @(negedge clk);

        // Max magnitude: -128 * -128 * 16 = 262144.
        fill_const(-8'sd128, -8'sd128);
        launch(1'b1);
        repeat (LAT) @(negedge clk);

        // Extra start mid-run and in the DONE cycle are ignored; restart right after DONE.
        fill_rand();
        launch(1'b1);
        repeat (4) @(negedge clk);
        bus.inner_start = 1'b1;
        @(negedge clk);
        bus.inner_start = 1'b0;
        repeat (12) @(negedge clk);
        bus.inner_start = 1'b1;
        @(negedge clk);
        fill_rand();
        launch(1'b1);
        repeat (LAT) @(negedge clk);

        // Abort by reset partway through a run, between clock edges.
        fill_rand();
        launch(1'b0);
        repeat (6) @(negedge clk);
        #6 rst = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NN; i++) begin
            mem_a[i] = DW'(i);
            mem_b[i] = 8'sd1;
        end
        launch(1'b1);
        repeat (LAT) @(negedge clk);

        // Random runs with random idle gaps, including back-to-back.
        for (int k = 0; k < 8; k++) begin
            fill_rand();
            launch(1'b1);
            repeat (LAT) @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Emulated top-level controller: start level held 3 cycles.
        fill_rand();
        ctl_state = 0;
        for (int t = 0; t < 4 * LAT; t++) begin
            ctl_start = (t < 3);
            bus.inner_start = 1'b0;
            if (ctl_state == 0 && ctl_start) begin
                bus.inner_start = 1'b1;
                cx.cyc = cyc + LAT;
                cx.res = ref_dot();
                sb.push_back(cx);
                ctl_state = 1;
            end else if (ctl_state == 1 && bus.done) begin
                ctl_state = 2;
            end
            if (ctl_state == 2) break;
            @(negedge clk);
        end
        bus.inner_start = 1'b0;
        ctrl_ok = (ctl_state == 2);
        repeat (3) @(negedge clk);
        finish_req = 1'b1;
    end

endmodule
